// File: rtl/beat_detector_multi.sv
// Multi-channel beat detector.
// Compares each accepted sample with the previous accepted sample and grades
// the largest per-channel change into three intensity levels. A detected beat
// is followed by a hold-off window, so one physical hit yields exactly one beat.
//
// state   | meaning
// --------+------------------------------------------------------------
// PRIME   | waiting for a first sample to seed prev; never beats
// ARMED   | evaluating each accepted sample for a beat
// HOLDOFF | beat suppression, counter runs down to re-arm
//
// Parameter constraints: LEVEL_1 < LEVEL_2 < LEVEL_3, HOLDOFF >= 1, and
// HOLDOFF must fit in HO_W bits.
module beat_detector_multi #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 3,
    parameter int LEVEL_1 = 100,
    parameter int LEVEL_2 = 300,
    parameter int LEVEL_3 = 500,
    parameter int HOLDOFF = 1000,
    parameter int HO_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic                     beat_en,
    output logic [1:0]               beat_intensity,
    output logic [NUM_CH-1:0]        beat_mask,
    output logic                     holdoff_busy
);

    // One extra bit lets the difference and its magnitude cover the full
    // two's complement span without overflow (e.g. -32768 -> 32767 = 65535).
    localparam int MAG_W = DATA_W + 1;

    localparam logic [MAG_W-1:0] TH_1   = MAG_W'(LEVEL_1);
    localparam logic [MAG_W-1:0] TH_2   = MAG_W'(LEVEL_2);
    localparam logic [MAG_W-1:0] TH_3   = MAG_W'(LEVEL_3);
    localparam logic [HO_W-1:0]  HO_INI = HO_W'(HOLDOFF);

    typedef enum logic [1:0] {
        S_PRIME   = 2'd0,
        S_ARMED   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HO_W-1:0]     cnt_q, cnt_d;
    logic                beat_q, beat_d;
    logic [1:0]          int_q, int_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;

    logic [DATA_W-1:0]   prev_q [NUM_CH];
    logic [MAG_W-1:0]    mag    [NUM_CH];
    logic [1:0]          lvl    [NUM_CH];
    logic [1:0]          max_lvl;
    logic [NUM_CH-1:0]   lvl_mask;
    logic                accept;

    assign accept = enable & sample_valid;

    // Per-channel signed difference, magnitude and level grading.
    always_comb begin
        logic [DATA_W-1:0] cur;
        logic [MAG_W-1:0]  diff;
        cur  = '0;
        diff = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cur  = sample_data[k*DATA_W +: DATA_W];
            diff = {cur[DATA_W-1], cur} - {prev_q[k][DATA_W-1], prev_q[k]};
            mag[k] = diff[MAG_W-1] ? (MAG_W'(0) - diff) : diff;
            if (mag[k] > TH_3) begin
                lvl[k] = 2'd3;
            end else if (mag[k] > TH_2) begin
                lvl[k] = 2'd2;
            end else if (mag[k] > TH_1) begin
                lvl[k] = 2'd1;
            end else begin
                lvl[k] = 2'd0;
            end
        end
    end

    // Highest level across channels and the set of channels that reach it.
    always_comb begin
        max_lvl  = 2'd0;
        lvl_mask = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (lvl[k] > max_lvl) begin
                max_lvl = lvl[k];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            lvl_mask[k] = (max_lvl != 2'd0) && (lvl[k] == max_lvl);
        end
    end

    // Next-state, hold-off counter and beat output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = 1'b0;
        int_d   = int_q;
        mask_d  = mask_q;
        if (!enable) begin
            state_d = S_PRIME;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_PRIME: begin
                    if (sample_valid) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_valid && (max_lvl != 2'd0)) begin
                        beat_d  = 1'b1;
                        int_d   = max_lvl;
                        mask_d  = lvl_mask;
                        cnt_d   = HO_INI;
                        state_d = S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    // Samples in this state only refresh prev; the last
                    // decrement (from 1) re-arms on the following cycle.
                    cnt_d = cnt_q - HO_W'(1);
                    if (cnt_q <= HO_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end
                end
                default: begin
                    state_d = S_PRIME;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_PRIME;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            int_q   <= 2'd0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            int_q   <= int_d;
            mask_q  <= mask_d;
        end
    end

    // Previous-sample registers follow every accepted sample in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                prev_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_CH; k++) begin
                prev_q[k] <= sample_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign beat_en        = beat_q;
    assign beat_intensity = int_q;
    assign beat_mask      = mask_q;
    assign holdoff_busy   = (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_beat_detector_multi.sv
// Directed bench for beat_detector_multi with a scoreboard of expected beats.
module tb_beat_detector_multi;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 3;
    localparam int HOLDOFF = 8;

    typedef struct {
        logic [1:0] inten;
        logic [2:0] mask;
    } beat_t;

    logic                     clk;
    logic                     rst;
    logic                     enable;
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic                     beat_en;
    logic [1:0]               beat_intensity;
    logic [NUM_CH-1:0]        beat_mask;
    logic                     holdoff_busy;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    beat_detector_multi #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .LEVEL_1(100),
        .LEVEL_2(300),
        .LEVEL_3(500),
        .HOLDOFF(HOLDOFF),
        .HO_W   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .beat_en       (beat_en),
        .beat_intensity(beat_intensity),
        .beat_mask     (beat_mask),
        .holdoff_busy  (holdoff_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Called at a falling edge; the sample is taken on the next rising edge.
    task automatic send(input logic signed [15:0] c0, input logic signed [15:0] c1,
                        input logic signed [15:0] c2, input bit expect_beat,
                        input logic [1:0] ei, input logic [2:0] em);
        beat_t b;
        sample_data  = {c2, c1, c0};
        sample_valid = 1'b1;
        if (expect_beat) begin
            b.inten = ei;
            b.mask  = em;
            exp_q.push_back(b);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every beat pulse must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (beat_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got intensity %0d mask %b, none expected at %0t",
                             beat_intensity, beat_mask, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_intensity", int'(beat_intensity), int'(e.inten));
                    chk("beat_mask", int'(beat_mask), int'(e.mask));
                    chk("busy_on_beat", int'(holdoff_busy), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        idle(2);
        chk("rst_beat_en", int'(beat_en), 0);
        chk("rst_intensity", int'(beat_intensity), 0);
        chk("rst_mask", int'(beat_mask), 0);
        chk("rst_busy", int'(holdoff_busy), 0);
        rst    = 1'b1;
        enable = 1'b1;
        idle(1);

        // Prime then first beat
        send(0, 0, 0, 0, 0, 0);
        send(150, 0, 0, 1, 1, 3'b001);
        chk("busy_after_beat", int'(holdoff_busy), 1);
        idle(10);

        // Threshold boundaries on channel 0
        send(250, 0, 0, 0, 0, 0);
        send(351, 0, 0, 1, 1, 3'b001);
        idle(10);
        send(651, 0, 0, 1, 1, 3'b001);
        idle(10);
        send(952, 0, 0, 1, 2, 3'b001);
        idle(10);
        send(1452, 0, 0, 1, 2, 3'b001);
        idle(10);
        send(1953, 0, 0, 1, 3, 3'b001);
        idle(10);

        // Negative delta and full-range wrap
        send(1953, 0, -600, 1, 3, 3'b100);
        idle(10);
        send(-32768, 0, -600, 1, 3, 3'b001);
        idle(10);
        send(32767, 0, -600, 1, 3, 3'b001);
        idle(10);
        send(0, 0, 0, 1, 3, 3'b101);
        idle(10);

        // Multi-channel tie
        send(350, -400, 120, 1, 2, 3'b011);
        idle(10);

        // Hold-off: suppressed sample, expiry-edge sample, prev tracking
        send(350, -400, 1120, 1, 3, 3'b100);
        idle(2);
        send(350, -400, 2120, 0, 0, 0);
        idle(4);
        send(350, -400, 3120, 0, 0, 0);
        chk("busy_after_expiry", int'(holdoff_busy), 0);
        send(350, -400, 3170, 0, 0, 0);

        // Re-arm timing: ARMED exactly HOLDOFF cycles after the beat cycle
        send(350, -400, 4170, 1, 3, 3'b100);
        idle(HOLDOFF - 1);
        chk("busy_last_holdoff_cycle", int'(holdoff_busy), 1);
        idle(1);
        chk("busy_rearmed", int'(holdoff_busy), 0);
        send(350, -400, 5170, 1, 3, 3'b100);
        idle(10);

        // Enable dropped during hold-off
        send(350, -400, 6170, 1, 3, 3'b100);
        idle(2);
        enable = 1'b0;
        idle(1);
        chk("busy_after_disable", int'(holdoff_busy), 0);
        chk("held_intensity", int'(beat_intensity), 3);
        chk("held_mask", int'(beat_mask), 4);
        enable = 1'b1;
        send(350, -400, 0, 0, 0, 0);
        send(350, -400, 200, 1, 1, 3'b100);

        // Asynchronous reset during the beat cycle
        #2;
        rst = 1'b0;
        #1;
        chk("async_beat_en", int'(beat_en), 0);
        chk("async_intensity", int'(beat_intensity), 0);
        chk("async_mask", int'(beat_mask), 0);
        chk("async_busy", int'(holdoff_busy), 0);
        @(negedge clk);
        rst = 1'b1;
        send(350, -400, 200, 0, 0, 0);
        send(470, -400, 200, 1, 1, 3'b001);
        idle(10);

        chk("pending_beats", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_detector_multi.md
Name: beat_detector_multi

Overview:
- Parametrised successor to the three-axis accelerometer beat generator.
- Compares each new multi-channel sample against the previous accepted sample using signed absolute difference, then classifies the largest change into one of three intensity levels.
- Emits a single-cycle beat pulse, then enforces a programmable hold-off so that one physical hit produces exactly one beat.
- Sits between the accelerometer sample interface and the audio/beat playback logic.

Parameters:
- DATA_W, 16, width of one channel sample, two's complement
- NUM_CH, 3, number of channels packed in sample_data
- LEVEL_1, 100, intensity-1 threshold (unsigned magnitude)
- LEVEL_2, 300, intensity-2 threshold; must be > LEVEL_1
- LEVEL_3, 500, intensity-3 threshold; must be > LEVEL_2
- HOLDOFF, 1000, clock cycles of beat suppression after a beat; minimum 1
- HO_W, 16, hold-off counter width; must hold HOLDOFF

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- enable  in  1  detector enable; low forces priming state
- sample_valid  in  1  one-cycle strobe, sample_data valid
- sample_data  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- beat_en  out  1  one-cycle beat pulse
- beat_intensity  out  2  intensity of last beat (1..3), 0 after reset
- beat_mask  out  NUM_CH  channels whose level equals the reported intensity at last beat
- holdoff_busy  out  1  high while in HOLDOFF state

Behaviour:
- Reset (rst low, async): state=PRIME; prev regs=0; hold-off counter=0; beat_en=0; beat_intensity=0; beat_mask=0; holdoff_busy=0.
- Sample acceptance: a sample is accepted on any clk edge with enable=1 and sample_valid=1. Every accepted sample updates the prev register for all channels, in every state.
- Difference: d_k = sample_k - prev_k, computed sign-extended to DATA_W+1 bits. mag_k = |d_k|, DATA_W+1 bits unsigned, with no overflow.
  - Example: prev=-32768, sample=+32767 gives mag=65535.
- Channel level:
  - lvl_k = 3 if mag_k > LEVEL_3
  - else 2 if mag_k > LEVEL_2
  - else 1 if mag_k > LEVEL_1
  - else 0
  - All comparisons are strict. Equality stays at the lower level. There are no gaps between levels.
- Sample intensity: max_lvl = max of lvl_k over all channels. mask = channels with lvl_k == max_lvl, provided max_lvl > 0.
- FSM:
  - PRIME: the first accepted sample loads prev only; no beat is evaluated. Go to ARMED.
  - ARMED: on an accepted sample with max_lvl > 0:
    - beat_en=1 on the next edge, i.e. latency of 1 cycle after the accepting edge.
    - Update beat_intensity and beat_mask.
    - Load counter=HOLDOFF and go to HOLDOFF.
    - If max_lvl == 0, stay in ARMED with no output change.
  - HOLDOFF: counter decrements every clk cycle while enable=1. Accepted samples update prev but never produce a beat. When counter reaches 1 and decrements, go to ARMED. With HOLDOFF=N, the first cycle ARMED again is exactly N cycles after the beat_en cycle.
- beat_en is registered and high for exactly one cycle per beat. beat_intensity and beat_mask hold their values until the next beat or reset.
- holdoff_busy = (state == HOLDOFF).
- enable low (any state): next edge goes to PRIME, clears the counter, and forces beat_en=0. prev is retained but is not used. beat_intensity and beat_mask hold their values.
- sample_valid while enable=0: ignored.
- Sample arriving on the same edge that HOLDOFF expires: the sample is still in HOLDOFF, so no beat is produced; prev is updated.
- Back-to-back sample_valid on consecutive cycles is supported at full rate.
- Reset mid-hold-off: all state clears asynchronously, and the next accepted sample is a priming sample.

Test Plan:
- Reset then enable=1 with NUM_CH=3. Accept sample (0,0,0), then (150,0,0) -> no beat on the first sample. beat_en pulses one cycle after the second, with intensity=1, mask=001, holdoff_busy=1.
- Threshold boundaries, ARMED state, single channel:
  - Deltas of exactly 100, then 101 -> no beat, then intensity 1.
  - Delta 300 -> intensity 1. Delta 301 -> intensity 2.
  - Delta 500 -> intensity 2. Delta 501 -> intensity 3.
  - Bench waits out hold-off between cases.
- Negative and wrap cases:
  - prev=0, sample=-600 on channel 2 -> intensity 3, mask=100.
  - prev=-32768, sample=32767 -> intensity 3, with no sign error.
- Multi-channel ties: deltas (350,-400,120) -> intensity 2, mask=011.
- Hold-off with HOLDOFF=8:
  - Beat, then a large delta 3 cycles later -> no second beat; prev is updated.
  - Large delta on the 8th cycle after beat_en -> beat.
  - Sample on the expiry edge -> no beat.
- Mid-operation disruption:
  - enable dropped during hold-off -> holdoff_busy falls next edge. After re-enable, the first sample primes only.
  - rst asserted asynchronously mid-hold-off -> all outputs 0 immediately.
